// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
// The controller side uses the master modport and the subtractor uses the slave modport.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, LSB first, one full-subtractor step per clock.
// Operands are captured on an accepted start and a done pulse marks a valid result.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] d_q;
  logic             br;
  logic             bout_q;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell on the current LSBs.
  logic             x;
  logic             diff;
  logic             br_next;
  logic             last;
  logic [WIDTH:0]   d_cat;

  assign x       = sa[0] ^ sb[0];
  assign diff    = x ^ br;
  assign br_next = (~sa[0] & sb[0]) | (~x & br);
  assign last    = (cnt == LAST);
  // The new difference bit enters at the MSB; slicing {diff, d} also covers WIDTH=1.
  assign d_cat   = {diff, d_q};

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: start is only honoured in IDLE, so requests during RUN/DONE are dropped.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, shift one bit per RUN cycle, latch borrow on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            br  <= bus.bin;
            cnt <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_next;
          d_q <= d_cat[WIDTH:1];
          cnt <= cnt + CW'(1);
          if (last) bout_q <= br_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=4 directed vectors and corner sequences,
// plus a WIDTH=8 instance exercised with random operands against a 9-bit reference.
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bout;
  } vec_t;

  vec_t       vecs[8];
  logic [3:0] last_d4;
  logic       last_bout4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One WIDTH=4 operation, called at a negedge with the DUT idle.
  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         input logic [3:0] exp_d, input logic exp_bout, input string tag);
    int lat;
    bit seen;
    bus4.a     = a;
    bus4.b     = b;
    bus4.bin   = bin;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.a     = ~a;
    bus4.b     = ~b;
    bus4.bin   = ~bin;
    check({tag, " busy"}, bus4.busy, 1);
    check({tag, " d_hold"}, {bus4.bout, bus4.d}, {last_bout4, last_d4});
    lat  = 1;
    seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus4.done) seen = 1;
    end
    check({tag, " latency"}, lat, 5);
    check({tag, " d"}, bus4.d, exp_d);
    check({tag, " bout"}, bus4.bout, exp_bout);
    last_d4    = exp_d;
    last_bout4 = exp_bout;
    @(negedge clk);
    check({tag, " done_width"}, bus4.done, 0);
    check({tag, " idle"}, bus4.busy, 0);
  endtask

  initial begin
    int         dcnt;
    int         last_done;
    int         wait_cnt;
    logic [8:0] ref9;
    logic [7:0] ra, rb;
    logic       rbin;
    int         lat;
    bit         seen;

    total = 0;
    bad   = 0;
    vecs[0] = '{4'd9,  4'd3,  1'b0, 4'h6, 1'b0};
    vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b0, 4'h0, 1'b0};
    vecs[4] = '{4'd7,  4'd7,  1'b1, 4'hF, 1'b1};
    vecs[5] = '{4'd8,  4'd1,  1'b0, 4'h7, 1'b0};
    vecs[6] = '{4'd0,  4'd15, 1'b0, 4'h1, 1'b1};
    vecs[7] = '{4'd15, 4'd0,  1'b1, 4'hE, 1'b0};

    rst = 1'b1;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    last_d4    = 4'h0;
    last_bout4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst busy4", bus4.busy, 0);
    check("rst done4", bus4.done, 0);
    check("rst d4", bus4.d, 0);
    check("rst bout4", bus4.bout, 0);
    check("rst d8", {bus8.bout, bus8.d}, 0);

    // Directed vectors
    for (int i = 0; i < 8; i++)
      run_op4(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, $sformatf("vec%0d", i));

    // start held high: done every 6 cycles, a/b scrambled while running
    dcnt      = 0;
    last_done = -1;
    bus4.start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus4.done) begin
        dcnt++;
        check("held d", bus4.d, 3);
        check("held bout", bus4.bout, 0);
        if (last_done >= 0) check("held interval", c - last_done, 6);
        else                check("held first", c, 5);
        last_done = c;
      end
      if (bus4.busy && !bus4.done) begin
        bus4.a = 4'($urandom);
        bus4.b = 4'($urandom);
      end else begin
        bus4.a = 4'd5;
        bus4.b = 4'd2;
      end
      bus4.bin = 1'b0;
      @(negedge clk);
    end
    check("held count", dcnt, 3);
    bus4.start = 1'b0;
    bus4.a = 4'd5;
    bus4.b = 4'd2;
    wait_cnt = 0;
    while ((bus4.busy || bus4.done) && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("held drain", bus4.busy, 0);
    check("held final d", bus4.d, 3);
    last_d4    = 4'd3;
    last_bout4 = 1'b0;

    // Reset during the 2nd RUN cycle
    bus4.a = 4'd1; bus4.b = 4'd2; bus4.bin = 1'b0; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    check("abort pre busy", bus4.busy, 1);
    rst = 1'b1;
    #1;
    check("abort busy", bus4.busy, 0);
    check("abort done", bus4.done, 0);
    check("abort d", bus4.d, 0);
    check("abort bout", bus4.bout, 0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus4.done) dcnt++;
    end
    check("abort no done", dcnt, 0);
    last_d4    = 4'h0;
    last_bout4 = 1'b0;
    run_op4(4'd12, 4'd5, 1'b1, 4'h6, 1'b0, "post_abort");

    // WIDTH=8 random vectors
    for (int n = 0; n < 256; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      if (n == 0) begin ra = 8'd0; rb = 8'd255; rbin = 1'b1; end
      if (n == 1) begin ra = 8'd255; rb = 8'd0; rbin = 1'b0; end
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      bus8.a = ra; bus8.b = rb; bus8.bin = rbin; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      bus8.a = ~ra; bus8.b = ~rb;
      lat  = 1;
      seen = 0;
      while (!seen && lat < 30) begin
        @(negedge clk);
        lat++;
        if (bus8.done) seen = 1;
      end
      check($sformatf("w8 lat %0d", n), lat, 9);
      check($sformatf("w8 res %0d", n), {bus8.bout, bus8.d}, ref9);
      @(negedge clk);
      check($sformatf("w8 done_width %0d", n), bus8.done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
